// File: rtl/cs_stream_ctrl.sv
// Host-side sequencer for the CS block: streams a pattern-memory run into CS,
// clears CS at the start of each run and captures one result per full window.
module cs_stream_ctrl #(
  parameter int N_SAMPLES = 64,
  parameter int ADDR_W    = 10,
  parameter int WIN       = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              cs_reset,
  output logic [7:0]        x_out,
  input  logic [9:0]        y_in,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_addr,
  output logic [9:0]        res_data
);

  localparam int CYC_W = $clog2(N_SAMPLES + 4);

  localparam logic [CYC_W-1:0] C_RD_LAST   = CYC_W'(N_SAMPLES - 1);
  localparam logic [CYC_W-1:0] C_CAP_FIRST = CYC_W'(WIN + 2);
  localparam logic [CYC_W-1:0] C_CAP_LAST  = CYC_W'(N_SAMPLES + 2);
  localparam logic [CYC_W-1:0] C_LAST      = CYC_W'(N_SAMPLES + 3);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CYC_W-1:0] cyc;
  logic             rd_en_d;

  // CS is cleared by our own reset and again on the first cycle of every run,
  // so nothing from a previous run lingers in its window or running sum.
  assign cs_reset = reset | ((state == RUN) && (cyc == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cyc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_en_d   <= 1'b0;
      rd_addr   <= '0;
      x_out     <= '0;
      res_valid <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
    end else begin
      rd_en_d   <= rd_en;
      res_valid <= 1'b0;
      done      <= 1'b0;
      // Memory has one cycle of latency; x_out holds its last sample afterwards.
      if (rd_en_d) x_out <= rd_data;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            cyc     <= '0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end
        RUN: begin
          cyc   <= cyc + CYC_W'(1);
          rd_en <= (cyc < C_RD_LAST);
          if (cyc < C_RD_LAST) rd_addr <= rd_addr + ADDR_W'(1);
          // Window k = cyc-11 is complete in CS during this cycle.
          if ((cyc >= C_CAP_FIRST) && (cyc <= C_CAP_LAST)) begin
            res_valid <= 1'b1;
            res_data  <= y_in;
            res_addr  <= ADDR_W'(cyc - C_CAP_FIRST);
          end
          if (cyc == C_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          cyc   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_stream_ctrl.sv
// Bench for cs_stream_ctrl: two instances (9 and 12 samples) share a pattern
// memory and each drives a behavioural CS window model.
module tb_cs_stream_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start9, start12;
  logic       busy9, busy12, done9, done12, rd_en9, rd_en12;
  logic [9:0] rd_addr9, rd_addr12, res_addr9, res_addr12;
  logic [7:0] rd_data9, rd_data12, x9, x12;
  logic       cs_reset9, cs_reset12, res_valid9, res_valid12;
  logic [9:0] y9, y12, res_data9, res_data12;

  cs_stream_ctrl #(.N_SAMPLES(9), .ADDR_W(10)) dut9 (
    .clk(clk), .reset(reset), .start(start9), .busy(busy9), .done(done9),
    .rd_en(rd_en9), .rd_addr(rd_addr9), .rd_data(rd_data9), .cs_reset(cs_reset9),
    .x_out(x9), .y_in(y9), .res_valid(res_valid9), .res_addr(res_addr9),
    .res_data(res_data9)
  );

  cs_stream_ctrl #(.N_SAMPLES(12), .ADDR_W(10)) dut12 (
    .clk(clk), .reset(reset), .start(start12), .busy(busy12), .done(done12),
    .rd_en(rd_en12), .rd_addr(rd_addr12), .rd_data(rd_data12), .cs_reset(cs_reset12),
    .x_out(x12), .y_in(y12), .res_valid(res_valid12), .res_addr(res_addr12),
    .res_data(res_data12)
  );

  // CS reference: Y = (sum + 9*appr) >> 3, appr = largest sample <= floor(sum/9).
  function automatic logic [9:0] cs_y(input logic [71:0] w);
    int sum, avg, appr, s;
    sum = 0;
    for (int i = 0; i < 9; i++) sum += int'(w[i*8 +: 8]);
    avg  = sum / 9;
    appr = 0;
    for (int i = 0; i < 9; i++) begin
      s = int'(w[i*8 +: 8]);
      if (s <= avg && s > appr) appr = s;
    end
    return 10'((sum + 9 * appr) >> 3);
  endfunction

  logic [7:0]  mem [0:1023];
  logic [71:0] win9, win12;

  always @(posedge clk) begin
    if (rd_en9)  rd_data9  <= mem[rd_addr9];
    if (rd_en12) rd_data12 <= mem[rd_addr12];
    win9  <= cs_reset9  ? 72'd0 : {win9[63:0], x9};
    win12 <= cs_reset12 ? 72'd0 : {win12[63:0], x12};
  end
  assign y9  = cs_y(win9);
  assign y12 = cs_y(win12);

  // Probe mux selects the instance under test.
  logic       cur;
  logic       m_busy, m_done, m_rd_en, m_cs_reset, m_res_valid;
  logic [9:0] m_rd_addr, m_res_addr, m_res_data;
  logic [7:0] m_x;
  assign m_busy      = cur ? busy12      : busy9;
  assign m_done      = cur ? done12      : done9;
  assign m_rd_en     = cur ? rd_en12     : rd_en9;
  assign m_rd_addr   = cur ? rd_addr12   : rd_addr9;
  assign m_cs_reset  = cur ? cs_reset12  : cs_reset9;
  assign m_x         = cur ? x12         : x9;
  assign m_res_valid = cur ? res_valid12 : res_valid9;
  assign m_res_addr  = cur ? res_addr12  : res_addr9;
  assign m_res_data  = cur ? res_data12  : res_data9;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (cur) start12 = v;
    else     start9  = v;
  endtask

  typedef struct {
    logic       sel;
    logic [7:0] base;
    logic [7:0] step;
    int         spur_c;
    logic       done_start;
    logic [9:0] exp_first;
  } run_vec_t;

  task automatic fill(input int n, input logic [7:0] base, input logic [7:0] step);
    logic [71:0] p;
    for (int i = 0; i < n; i++) mem[i] = 8'(base + step * i);
    exp_q.delete();
    for (int k = 0; k <= n - 9; k++) begin
      for (int j = 0; j < 9; j++) p[j*8 +: 8] = mem[k + j];
      exp_q.push_back(cs_y(p));
    end
  endtask

  task automatic run_one(input run_vec_t v, input int id);
    int n;
    logic vexp;
    logic [9:0] e;
    n   = v.sel ? 12 : 9;
    cur = v.sel;
    fill(n, v.base, v.step);
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    for (int c = 0; c <= n + 4; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("r%0d c%0d busy", id, c), m_busy, 1);
      chk($sformatf("r%0d c%0d done", id, c), m_done, (c == n + 4));
      chk($sformatf("r%0d c%0d rd_en", id, c), m_rd_en, (c < n));
      if (c < n) chk($sformatf("r%0d c%0d rd_addr", id, c), m_rd_addr, c);
      chk($sformatf("r%0d c%0d cs_reset", id, c), m_cs_reset, (c == 0));
      if (c >= 2 && c <= n + 1) chk($sformatf("r%0d c%0d x_out", id, c), m_x, mem[c-2]);
      vexp = (c >= 12 && c <= n + 3);
      chk($sformatf("r%0d c%0d res_valid", id, c), m_res_valid, vexp);
      if (vexp) begin
        chk($sformatf("r%0d c%0d res_addr", id, c), m_res_addr, c - 12);
        e = exp_q.pop_front();
        chk($sformatf("r%0d c%0d res_data", id, c), m_res_data, e);
        if (c == 12) chk($sformatf("r%0d first result", id), m_res_data, v.exp_first);
      end
      drive_start((c == v.spur_c) || (v.done_start && c == n + 4));
    end
    @(negedge clk);
    drive_start(1'b0);
    chk($sformatf("r%0d idle busy", id), m_busy, 0);
    chk($sformatf("r%0d idle done", id), m_done, 0);
    chk($sformatf("r%0d idle res_valid", id), m_res_valid, 0);
    chk($sformatf("r%0d idle res_addr hold", id), m_res_addr, n - 9);
    if (v.done_start) begin
      @(negedge clk);
      chk($sformatf("r%0d start in DONE ignored", id), m_busy, 0);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " busy"}, m_busy, 0);
    chk({tag, " done"}, m_done, 0);
    chk({tag, " rd_en"}, m_rd_en, 0);
    chk({tag, " rd_addr"}, m_rd_addr, 0);
    chk({tag, " x_out"}, m_x, 0);
    chk({tag, " res_valid"}, m_res_valid, 0);
    chk({tag, " res_addr"}, m_res_addr, 0);
    chk({tag, " res_data"}, m_res_data, 0);
    chk({tag, " cs_reset"}, m_cs_reset, 1);
  endtask

  run_vec_t vecs [7];

  initial begin
    // sel, base, step, spurious-start cycle, start-in-DONE, hand-computed first result
    vecs[0] = '{1'b0,  8'd10, 8'd0, -1, 1'b0, 10'd22};
    vecs[1] = '{1'b0,   8'd1, 8'd1, -1, 1'b0, 10'd11};
    vecs[2] = '{1'b1,   8'd1, 8'd1,  5, 1'b0, 10'd11};
    vecs[3] = '{1'b1, 8'd200, 8'd0, -1, 1'b0, 10'd450};
    vecs[4] = '{1'b1,  8'd10, 8'd0, -1, 1'b1, 10'd22};
    vecs[5] = '{1'b0, 8'd255, 8'd0, -1, 1'b0, 10'd573};
    vecs[6] = '{1'b1,   8'd3, 8'd7, -1, 1'b0, 10'd69};

    cur     = 1'b0;
    start9  = 1'b0;
    start12 = 1'b0;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    cur = 1'b0; chk_reset_state("rst n9");
    cur = 1'b1; chk_reset_state("rst n12");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_one(vecs[i], i);

    // Abort at RUN cycle 7, then a clean run.
    cur = 1'b1;
    fill(12, 8'd1, 8'd1);
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1 chk("abort cs_reset during reset", m_cs_reset, 1);
    @(negedge clk);
    chk_reset_state("abort");
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("abort idle%0d done", i), m_done, 0);
      chk($sformatf("abort idle%0d busy", i), m_busy, 0);
    end
    run_one(vecs[2], 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
